// File: rtl/bus_master_if.sv
// Initiator-side bus interface: single-word read/write with request/grant arbitration.
// Optional slave-ready timeout abort is built in when BUS_TIMEOUT_EN is defined.
module bus_master_if #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned TO_CNT_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [29:0] cpu_addr,
  input  logic [31:0] cpu_wr_data,
  output logic [31:0] cpu_rd_data,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic        m_req_,
  input  logic        m_grnt_,
  output logic        m_as_,
  output logic        m_rw,
  output logic [29:0] m_addr,
  output logic [31:0] m_wr_data,
  input  logic [31:0] m_rd_data,
  input  logic        m_rdy_
);

  localparam logic CmdRead = 1'b1;

  typedef enum logic [1:0] {StIdle, StReq, StAccess, StWait} state_e;

  state_e state;

`ifdef BUS_TIMEOUT_EN
  localparam logic [TO_CNT_W-1:0] ToMax = TO_CNT_W'(TIMEOUT_CYC);

  logic [TO_CNT_W-1:0] to_cnt;
  logic                timed_out;

  assign timed_out = (to_cnt == ToMax);
`else
  logic unused_to_cfg;

  assign unused_to_cfg = ^{TIMEOUT_CYC, TO_CNT_W};
  assign cpu_err       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StIdle;
      m_req_      <= 1'b1;
      m_as_       <= 1'b1;
      m_rw        <= CmdRead;
      m_addr      <= '0;
      m_wr_data   <= '0;
      cpu_rd_data <= '0;
      cpu_busy    <= 1'b0;
      cpu_done    <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      cpu_err     <= 1'b0;
      to_cnt      <= '0;
`endif
    end else begin
      cpu_done <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      cpu_err  <= 1'b0;
`endif
      unique case (state)
        StIdle: begin
          if (cpu_req) begin
            m_rw      <= cpu_rw;
            m_addr    <= cpu_addr;
            m_wr_data <= cpu_wr_data;
            m_req_    <= 1'b0;
            cpu_busy  <= 1'b1;
            state     <= StReq;
          end
        end
        StReq: begin
          if (!m_grnt_) begin
            m_as_ <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            to_cnt <= '0;
`endif
            state <= StAccess;
          end
        end
        // Grant is not re-checked here: the arbiter holds it while m_req_ is low.
        StAccess, StWait: begin
          if (!m_rdy_) begin
            if (m_rw == CmdRead) cpu_rd_data <= m_rd_data;
            cpu_done <= 1'b1;
            m_req_   <= 1'b1;
            m_as_    <= 1'b1;
            cpu_busy <= 1'b0;
            state    <= StIdle;
          end
`ifdef BUS_TIMEOUT_EN
          else if (timed_out) begin
            cpu_err  <= 1'b1;
            m_req_   <= 1'b1;
            m_as_    <= 1'b1;
            cpu_busy <= 1'b0;
            state    <= StIdle;
          end
`endif
          else begin
            m_as_ <= 1'b1;
`ifdef BUS_TIMEOUT_EN
            to_cnt <= to_cnt + TO_CNT_W'(1);
`endif
            state <= StWait;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_if.sv
// Self-checking bench for bus_master_if: vector table, hand sequences and random transactions
// checked against a cycle-count / data model derived from the transaction rules.
module tb_bus_master_if;

  localparam int unsigned ToCyc = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_rw;
  logic [29:0] cpu_addr;
  logic [31:0] cpu_wr_data;
  logic [31:0] cpu_rd_data;
  logic        cpu_busy;
  logic        cpu_done;
  logic        cpu_err;
  logic        m_req_;
  logic        m_grnt_;
  logic        m_as_;
  logic        m_rw;
  logic [29:0] m_addr;
  logic [31:0] m_wr_data;
  logic [31:0] m_rd_data;
  logic        m_rdy_;

  int          n_pass = 0;
  int          n_chk  = 0;
  logic [31:0] exp_rd;

  always #5 clk = ~clk;

  bus_master_if #(
    .TIMEOUT_CYC (ToCyc),
    .TO_CNT_W    (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_rw      (cpu_rw),
    .cpu_addr    (cpu_addr),
    .cpu_wr_data (cpu_wr_data),
    .cpu_rd_data (cpu_rd_data),
    .cpu_busy    (cpu_busy),
    .cpu_done    (cpu_done),
    .cpu_err     (cpu_err),
    .m_req_      (m_req_),
    .m_grnt_     (m_grnt_),
    .m_as_       (m_as_),
    .m_rw        (m_rw),
    .m_addr      (m_addr),
    .m_wr_data   (m_wr_data),
    .m_rd_data   (m_rd_data),
    .m_rdy_      (m_rdy_)
  );

  typedef struct {
    logic        rw;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          g;
    int          w;
    logic        b2b;
    logic        poke;
    int          exp_lat;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " m_req_"}, 32'(m_req_), 32'd1);
    check({tag, " m_as_"}, 32'(m_as_), 32'd1);
    check({tag, " m_rw"}, 32'(m_rw), 32'd1);
    check({tag, " m_addr"}, 32'(m_addr), 32'd0);
    check({tag, " m_wr_data"}, m_wr_data, 32'd0);
    check({tag, " cpu_rd_data"}, cpu_rd_data, 32'd0);
    check({tag, " cpu_busy"}, 32'(cpu_busy), 32'd0);
    check({tag, " cpu_done"}, 32'(cpu_done), 32'd0);
    check({tag, " cpu_err"}, 32'(cpu_err), 32'd0);
  endtask

  // Starts a transaction in the current cycle and returns in the cycle cpu_done is visible.
  // Grant comes after g cycles of m_req_ low; the slave answers after w wait cycles.
  task automatic run_txn(input logic rw, input logic [29:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int g, input int w, input logic poke,
                         input int exp_lat, input logic [31:0] exp_rdv);
    int  req_cyc = 0;
    int  ws      = 0;
    int  as_cnt  = 0;
    int  lat     = 0;
    bit  seen_as = 0;
    bit  done    = 0;
    bit  stable  = 1;
    bit  busy_ok = 1;
    bit  err_hit = 0;
    cpu_req     = 1'b1;
    cpu_rw      = rw;
    cpu_addr    = addr;
    cpu_wr_data = wdata;
    m_grnt_     = 1'b1;
    m_rdy_      = 1'b1;
    while (!done && lat < exp_lat + 20) begin
      cycle();
      lat++;
      cpu_req     = 1'b0;
      cpu_rw      = 1'($urandom);
      cpu_addr    = 30'($urandom);
      cpu_wr_data = $urandom;
      if (lat == 1) check("req_lowered", 32'(m_req_), 32'd0);
      if (cpu_err) err_hit = 1;
      if (cpu_done) begin
        done = 1;
      end else begin
        if (poke && lat == 3) cpu_req = 1'b1;
        if (!cpu_busy) busy_ok = 0;
        if (m_req_ || m_rw !== rw || m_addr !== addr || m_wr_data !== wdata) stable = 0;
        if (!m_as_) begin
          as_cnt++;
          seen_as = 1;
          ws      = 0;
        end else if (seen_as) begin
          ws++;
        end
        if (!m_req_) req_cyc++;
        m_grnt_   = (seen_as || req_cyc <= g) ? 1'b1 : 1'b0;
        m_rdy_    = (seen_as && ws == w) ? 1'b0 : 1'b1;
        m_rd_data = m_rdy_ ? $urandom : rdata;
      end
    end
    check("done_latency", done ? 32'(lat) : 32'hFFFF_FFFF, 32'(exp_lat));
    check("as_low_cycles", 32'(as_cnt), 32'd1);
    check("bus_stable", 32'(stable), 32'd1);
    check("busy_during", 32'(busy_ok), 32'd1);
    check("no_err", 32'(err_hit), 32'd0);
    check("rd_data", cpu_rd_data, exp_rdv);
    check("done_idle", {29'd0, m_req_, m_as_, cpu_busy}, 32'b110);
    m_grnt_ = 1'b1;
    m_rdy_  = 1'b1;
  endtask

  initial begin
    int lat;
    int err_at;
    int err_cnt;
    bit done_seen;

    tbl[0] = '{1'b1, 30'h100,      32'h0,        32'hDEADBEEF, 0,  0, 1'b0, 1'b0, 3,  32'hDEADBEEF};
    tbl[1] = '{1'b0, 30'h2A,       32'h12345678, 32'h55AA55AA, 0,  4, 1'b0, 1'b0, 7,  32'hDEADBEEF};
    tbl[2] = '{1'b1, 30'h3FFFFFFF, 32'h0,        32'hCAFEF00D, 10, 0, 1'b0, 1'b1, 13, 32'hCAFEF00D};
    tbl[3] = '{1'b1, 30'h155,      32'h0,        32'h0BADC0DE, 0,  2, 1'b1, 1'b0, 5,  32'h0BADC0DE};
    tbl[4] = '{1'b0, 30'h2AAAAAAA, 32'hFFFFFFFF, 32'h0,        2,  1, 1'b0, 1'b0, 6,  32'h0BADC0DE};

    reset       = 1'b1;
    cpu_req     = 1'b0;
    cpu_rw      = 1'b0;
    cpu_addr    = '0;
    cpu_wr_data = '0;
    m_grnt_     = 1'b1;
    m_rd_data   = '0;
    m_rdy_      = 1'b1;
    cycle();
    cycle();
    check_reset_vals("reset");
    reset = 1'b0;
    cycle();

    for (int i = 0; i < 5; i++) begin
      run_txn(tbl[i].rw, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, tbl[i].g, tbl[i].w,
              tbl[i].poke, tbl[i].exp_lat, tbl[i].exp_rd);
      if (!tbl[i].b2b) begin
        cycle();
        check("idle_gap", {30'd0, m_req_, cpu_busy}, 32'b10);
      end
    end
    exp_rd = tbl[4].exp_rd;

    for (int i = 0; i < 40; i++) begin
      logic        rw;
      logic [31:0] rdata;
      int          g;
      int          w;
      rw    = 1'($urandom);
      rdata = $urandom;
      g     = int'($urandom_range(0, 3));
      w     = int'($urandom_range(0, 5));
      if (rw) exp_rd = rdata;
      run_txn(rw, 30'($urandom), $urandom, rdata, g, w, 1'($urandom), 3 + g + w, exp_rd);
      if ($urandom_range(0, 1) == 0) cycle();
    end
    cycle();

    // Slave never answers.
    cpu_req   = 1'b1;
    cpu_rw    = 1'b1;
    cpu_addr  = 30'h77;
    m_grnt_   = 1'b0;
    m_rdy_    = 1'b1;
    lat       = 0;
    err_at    = 0;
    err_cnt   = 0;
    done_seen = 0;
`ifdef BUS_TIMEOUT_EN
    repeat (int'(ToCyc) + 8) begin
`else
    repeat (300) begin
`endif
      cycle();
      lat++;
      cpu_req = 1'b0;
      if (!m_as_) m_grnt_ = 1'b1;
      if (cpu_done) done_seen = 1;
      if (cpu_err) begin
        err_cnt++;
        if (err_at == 0) err_at = lat;
      end
    end
    check("to_no_done", 32'(done_seen), 32'd0);
    check("to_rd_kept", cpu_rd_data, exp_rd);
`ifdef BUS_TIMEOUT_EN
    check("to_err_edge", 32'(err_at), 32'(3 + ToCyc));
    check("to_err_pulses", 32'(err_cnt), 32'd1);
    check("to_idle", {29'd0, m_req_, m_as_, cpu_busy}, 32'b110);
`else
    check("to_no_err", 32'(err_cnt), 32'd0);
    check("to_stuck", {29'd0, m_req_, m_as_, cpu_busy}, 32'b011);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    exp_rd = '0;
`endif
    m_grnt_ = 1'b1;
    cycle();

    // Reset while waiting on the slave.
    cpu_req     = 1'b1;
    cpu_rw      = 1'b0;
    cpu_addr    = 30'h3C;
    cpu_wr_data = 32'hA5A5A5A5;
    m_grnt_     = 1'b0;
    m_rdy_      = 1'b1;
    cycle();
    cpu_req = 1'b0;
    repeat (4) cycle();
    check("wait_busy", {30'd0, m_req_, cpu_busy}, 32'b01);
    reset = 1'b1;
    cycle();
    check_reset_vals("rst_in_wait");
    reset   = 1'b0;
    m_grnt_ = 1'b1;
    cycle();
    check("post_rst_quiet", {29'd0, cpu_done, cpu_err, cpu_busy}, 32'd0);
    exp_rd = '0;

    run_txn(1'b1, 30'h1, 32'h0, 32'h13579BDF, 1, 1, 1'b0, 5, 32'h13579BDF);
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bus_master_if.md
Name: bus_master_if

Overview:
- Initiator-side bus interface; issues single-word read/write transactions on the shared bus on behalf of a local requester (CPU IF/MEM stage or DMA).
- Performs request/grant arbitration, drives address strobe and command, waits for the selected slave's ready, and returns read data to the requester.
- Sits between the requester and the bus arbiter / master mux. It consumes the read data and ready returned by the slave-side mux.

Parameters:
- TIMEOUT_CYC, 255: maximum cycles from entering ACCESS to slave ready before abort; only used when BUS_TIMEOUT_EN is defined.
- TO_CNT_W, 8: width of the timeout counter; must hold TIMEOUT_CYC.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cpu_req  input  1  one-cycle start strobe; sampled only in IDLE.
- cpu_rw  input  1  1 = READ, 0 = WRITE.
- cpu_addr  input  30  word address.
- cpu_wr_data  input  32  write data.
- cpu_rd_data  output  32  captured read data; held until the next read completes.
- cpu_busy  output  1  high whenever state != IDLE.
- cpu_done  output  1  one-cycle pulse when the transaction completes.
- cpu_err  output  1  one-cycle pulse on timeout abort.
- m_req_  output  1  bus request, active-low.
- m_grnt_  input  1  bus grant, active-low.
- m_as_  output  1  address strobe, active-low; asserted exactly one cycle.
- m_rw  output  1  command to the bus.
- m_addr  output  30  bus address.
- m_wr_data  output  32  bus write data.
- m_rd_data  input  32  read data from the slave mux.
- m_rdy_  input  1  ready from the slave mux, active-low.

Behaviour:
- Reset:
  - State returns to IDLE.
  - m_req_ = 1, m_as_ = 1, m_rw = READ.
  - m_addr = 0, m_wr_data = 0, cpu_rd_data = 0.
  - cpu_busy = 0, cpu_done = 0, cpu_err = 0, timeout counter = 0.
  - A reset in mid-transaction aborts it at that edge; no done or err pulse is produced.
- All outputs are registered.
- States are IDLE, REQ, ACCESS, WAIT.
- IDLE:
  - If cpu_req = 1, latch cpu_rw, cpu_addr and cpu_wr_data into m_rw, m_addr and m_wr_data.
  - Drive m_req_ = 0 and go to REQ.
  - cpu_req is ignored in every other state; there is no queueing.
- REQ:
  - Hold m_req_ = 0.
  - When m_grnt_ = 0 is sampled, drive m_as_ = 0, clear the timeout counter and go to ACCESS.
  - Waiting for grant is unbounded.
- ACCESS (m_as_ low for this one cycle):
  - Sample m_rdy_ in this cycle; a zero-wait-state slave may answer here.
  - If m_rdy_ = 0, complete the transaction (see completion rule).
  - Otherwise drive m_as_ = 1 and go to WAIT.
- WAIT:
  - Keep m_req_ = 0; address, command and write data stay stable.
  - If m_rdy_ = 0, complete the transaction.
  - Otherwise increment the timeout counter.
- Completion:
  - On a READ, cpu_rd_data <= m_rd_data; on a WRITE, cpu_rd_data is unchanged.
  - cpu_done = 1 for one cycle.
  - m_req_ = 1, m_as_ = 1, state returns to IDLE.
- Latency from cpu_req to cpu_done, with grant already available:
  - zero-wait slave: 3 edges (REQ, ACCESS, done);
  - each slave wait cycle adds 1.
- Back-to-back operation: cpu_req is accepted in the cycle cpu_done is high, because the state is IDLE at that point. The bus request is re-raised one cycle later.
- Grant change: m_grnt_ deassertion after ACCESS is ignored, since the arbiter keeps the grant while m_req_ is low.
- Simultaneous events: m_rdy_ = 0 on the same edge that the timeout would fire counts as a completion, not an error.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - In ACCESS/WAIT, when the counter reaches TIMEOUT_CYC with m_rdy_ still high, abort the transaction.
  - Abort produces cpu_err = 1 for one cycle, with no cpu_done and cpu_rd_data unchanged.
  - m_req_ and m_as_ go to 1 and the state returns to IDLE.
- Not defined:
  - The counter and the cpu_err logic are removed; cpu_err is tied to 0.
  - WAIT persists until m_rdy_ = 0.

Test Plan:
- Read, zero-wait slave: cpu_req with rw = READ, addr = 30'h100; grant 1 cycle after request; m_rdy_ = 0 in ACCESS with m_rd_data = 32'hDEADBEEF. Required: m_as_ low exactly 1 cycle, cpu_done pulses on the 3rd edge, cpu_rd_data = 32'hDEADBEEF, m_req_ returns to 1.
- Write with 4 wait states: addr = 30'h2A, wr_data = 32'h12345678. Required: m_addr, m_wr_data and m_rw = 0 stable through WAIT; cpu_done 4 cycles later than the zero-wait case; cpu_rd_data unchanged.
- Grant delayed 10 cycles. Required: m_req_ low for 10 cycles, m_as_ high until the grant, cpu_busy = 1 throughout, a second cpu_req during this time is ignored.
- Back-to-back: new cpu_req in the cpu_done cycle. Required: second transaction completes with its own address; m_req_ high for exactly 1 cycle between the two transactions.
- Timeout (BUS_TIMEOUT_EN, TIMEOUT_CYC = 8): m_rdy_ held high. Required: cpu_err pulses, cpu_done never pulses, state returns to IDLE, bus outputs idle. Without the macro, the block stays in WAIT indefinitely.
- Reset asserted in WAIT. Required: next edge shows all outputs at reset values, with no done or err pulse.
